imem_loader: RTL and testbench

Boot-time instruction memory and loader that sits directly upstream of the single-cycle core's fetch path. After reset it holds the core in reset, accepts a program as a big-endian byte stream over a valid/ready handshake, and writes it into a word-addressed instruction array. It then releases the core and serves `instr` combinationally from the core's `pc`.

---
 rtl/imem_loader.sv | 194 +++++++++++++++++++
 tb/tb_imem_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time instruction memory and byte-stream loader. Holds
//                the core in reset while a big-endian program stream is
//                written into a word-addressed array over a valid/ready
//                handshake, then releases the core and serves instructions
//                combinationally from the core's pc.
//  Options     : IMEM_LOADER_CHECKSUM_EN - treat the word terminated by
//                load_last as a 32-bit wrap-around checksum of all words
//                written before it; mismatch sends the loader to ERROR.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic              core_reset,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH_WORDS);
    localparam logic [ADDR_W:0] C_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [1:0]          cnt_q,   cnt_d;
    logic [31:0]         asm_q,   asm_d;
    logic [ADDR_W:0]     wptr_q,  wptr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]         sum_q,   sum_d;
`endif

    // Instruction array; deliberately not reset so it maps onto RAM.
    logic [31:0]         mem_q [DEPTH_WORDS];
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_waddr;
    logic [31:0]         w_mem_wdata;

    // ------------------------------------------------------------------------
    // Datapath wires
    // ------------------------------------------------------------------------
    logic                w_accept;
    logic                w_complete;
    logic                w_full;
    logic [31:0]         w_lane;
    logic [31:0]         w_word;
    logic [ADDR_W-1:0]   w_fetch_idx;
    logic                w_in_range;
    logic [1:0]          w_unused_pc;

    assign w_accept    = load_valid & ready_q;
    // A word completes on the 4th byte or early when load_last pads it.
    assign w_complete  = w_accept & ((cnt_q == 2'd3) | load_last);
    assign w_full      = (wptr_q == C_DEPTH);
    // The assembly register keeps unfilled lower lanes at zero, so OR-ing
    // the current lane in yields the padded word directly.
    assign w_word      = asm_q | w_lane;

    assign w_fetch_idx = pc[ADDR_W+1:2];
    assign w_in_range  = (pc[31:ADDR_W+2] == '0);
    assign w_unused_pc = pc[1:0];

    // Place the incoming byte into its big-endian lane.
    always_comb begin
        w_lane = 32'h0;
        case (cnt_q)
            2'd0:    w_lane = {load_byte, 24'h0};
            2'd1:    w_lane = {8'h0, load_byte, 16'h0};
            2'd2:    w_lane = {16'h0, load_byte, 8'h0};
            default: w_lane = {24'h0, load_byte};
        endcase
    end

    // Loader next-state: byte assembly, word commit, overflow and termination.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        wptr_d      = wptr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        w_mem_we    = 1'b0;
        w_mem_waddr = wptr_q[ADDR_W-1:0];
        w_mem_wdata = w_word;

        if (w_accept) begin
            if (w_complete) begin
                cnt_d = 2'd0;
                asm_d = 32'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (load_last) begin
                    // Terminating word is the checksum and is never stored.
                    state_d = (w_word == sum_q) ? ST_RUN : ST_ERROR;
                end else if (w_full) begin
                    state_d = ST_ERROR;
                end else begin
                    w_mem_we = 1'b1;
                    wptr_d   = wptr_q + C_ONE;
                    sum_d    = sum_q + w_word;
                end
`else
                if (w_full) begin
                    // Overflow beats load_last: nothing is written.
                    state_d = ST_ERROR;
                end else begin
                    w_mem_we = 1'b1;
                    wptr_d   = wptr_q + C_ONE;
                    if (load_last) begin
                        state_d = ST_RUN;
                    end
                end
`endif
            end else begin
                cnt_d = cnt_q + 2'd1;
                asm_d = w_word;
            end
        end

        // Ready is registered and follows the state we are entering.
        ready_d = (state_d == ST_LOAD);
    end

    // Control and pointer registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
            ready_q <= 1'b0;
            cnt_q   <= 2'd0;
            asm_q   <= 32'h0;
            wptr_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            wptr_q  <= wptr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Instruction array write port.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            mem_q[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Combinational fetch; nop outside RUN or outside the array window.
    always_comb begin
        instr = 32'h0;
        if ((state_q == ST_RUN) && w_in_range) begin
            instr = mem_q[w_fetch_idx];
        end
    end

    assign load_ready   = ready_q;
    assign core_reset   = (state_q != ST_RUN);
    assign load_done    = (state_q == ST_RUN);
    assign load_error   = (state_q == ST_ERROR);
    assign words_loaded = wptr_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Drives directed byte
//                streams from tables and compares against hand-computed
//                word counts and fetched instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    typedef struct {
        logic [7:0] b;
        logic       last;
        int         words;
        logic       core_rst;
    } load_vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_vec_t;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        core_reset;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic        load_error;
    logic [8:0]  words_loaded;

    logic [31:0] pc2;
    logic [31:0] instr2;
    logic        core_reset2;
    logic        load_valid2;
    logic [7:0]  load_byte2;
    logic        load_last2;
    logic        load_ready2;
    logic        load_done2;
    logic        load_error2;
    logic [2:0]  words_loaded2;

    int errors;
    int checks;

    load_vec_t  lq[$];
    fetch_vec_t fq[$];

    imem_loader #(.DEPTH_WORDS(256), .ADDR_W(8)) dut (
        .clock(clock), .reset(reset), .pc(pc), .instr(instr),
        .core_reset(core_reset), .load_valid(load_valid),
        .load_byte(load_byte), .load_last(load_last),
        .load_ready(load_ready), .load_done(load_done),
        .load_error(load_error), .words_loaded(words_loaded)
    );

    imem_loader #(.DEPTH_WORDS(4), .ADDR_W(2)) dut_small (
        .clock(clock), .reset(reset), .pc(pc2), .instr(instr2),
        .core_reset(core_reset2), .load_valid(load_valid2),
        .load_byte(load_byte2), .load_last(load_last2),
        .load_ready(load_ready2), .load_done(load_done2),
        .load_error(load_error2), .words_loaded(words_loaded2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        load_valid  = 1'b0;
        load_last   = 1'b0;
        load_valid2 = 1'b0;
        load_last2  = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n;
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        n = 0;
        while (!load_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!load_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake: ready timeout got 0 expected 1");
        end else begin
            @(posedge clock);
            #1;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b, input logic last);
        int n;
        load_valid2 = 1'b1;
        load_byte2  = b;
        load_last2  = last;
        n = 0;
        while (!load_ready2 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!load_ready2) begin
            checks++;
            errors++;
            $display("FAIL handshake2: ready timeout got 0 expected 1");
        end else begin
            @(posedge clock);
            #1;
        end
        load_valid2 = 1'b0;
        load_last2  = 1'b0;
    endtask

    // Apply the load table, checking word count and core reset after each byte.
    task automatic run_load(input string tag);
        for (int i = 0; i < lq.size(); i++) begin
            send(lq[i].b, lq[i].last);
            chk($sformatf("%s words[%0d]", tag, i), 32'(words_loaded), 32'(lq[i].words));
            chk($sformatf("%s core_reset[%0d]", tag, i), 32'(core_reset), 32'(lq[i].core_rst));
        end
    endtask

    // Apply the fetch table in RUN.
    task automatic run_fetch(input string tag);
        for (int i = 0; i < fq.size(); i++) begin
            pc = fq[i].pc;
            #1;
            chk($sformatf("%s instr pc=%h", tag, fq[i].pc), instr, fq[i].instr);
        end
        pc = 32'h0;
    endtask

    function automatic load_vec_t lv(input logic [7:0] b, input logic last,
                                     input int words, input logic cr);
        load_vec_t v;
        v.b = b; v.last = last; v.words = words; v.core_rst = cr;
        return v;
    endfunction

    function automatic fetch_vec_t fv(input logic [31:0] p, input logic [31:0] d);
        fetch_vec_t v;
        v.pc = p; v.instr = d;
        return v;
    endfunction

    initial begin
        errors      = 0;
        checks      = 0;
        pc          = 32'h0;
        pc2         = 32'h0;
        load_byte   = 8'h0;
        load_byte2  = 8'h0;
        load_valid  = 1'b0;
        load_last   = 1'b0;
        load_valid2 = 1'b0;
        load_last2  = 1'b0;
        reset       = 1'b1;
        #12;

        // ---------------- reset state ----------------
        chk("rst core_reset", 32'(core_reset), 32'd1);
        chk("rst ready", 32'(load_ready), 32'd0);
        chk("rst done", 32'(load_done), 32'd0);
        chk("rst error", 32'(load_error), 32'd0);
        chk("rst words", 32'(words_loaded), 32'd0);
        chk("rst instr", instr, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("ready before edge", 32'(load_ready), 32'd0);
        idle(1);
        chk("ready after edge", 32'(load_ready), 32'd1);

`ifndef IMEM_LOADER_CHECKSUM_EN
        // ---------------- 8-byte program ----------------
        lq = {};
        lq.push_back(lv(8'h20, 1'b0, 0, 1'b1));
        lq.push_back(lv(8'h08, 1'b0, 0, 1'b1));
        lq.push_back(lv(8'h00, 1'b0, 0, 1'b1));
        lq.push_back(lv(8'h05, 1'b0, 1, 1'b1));
        lq.push_back(lv(8'h8C, 1'b0, 1, 1'b1));
        lq.push_back(lv(8'h09, 1'b0, 1, 1'b1));
        lq.push_back(lv(8'h00, 1'b0, 1, 1'b1));
        lq.push_back(lv(8'h04, 1'b1, 2, 1'b0));
        run_load("prog8");
        chk("prog8 done", 32'(load_done), 32'd1);
        chk("prog8 ready", 32'(load_ready), 32'd0);
        fq = {};
        fq.push_back(fv(32'h0000_0000, 32'h2008_0005));
        fq.push_back(fv(32'h0000_0004, 32'h8C09_0004));
        fq.push_back(fv(32'h0000_0006, 32'h8C09_0004));
        fq.push_back(fv(32'h0000_0400, 32'h0));
        fq.push_back(fv(32'h8000_0000, 32'h0));
        run_fetch("prog8");
        // Bytes offered in RUN must be ignored.
        load_valid = 1'b1;
        load_byte  = 8'hFF;
        idle(2);
        load_valid = 1'b0;
        chk("run ignores bytes", 32'(words_loaded), 32'd2);

        // ---------------- padded last word ----------------
        do_reset();
        lq = {};
        lq.push_back(lv(8'hAA, 1'b0, 0, 1'b1));
        lq.push_back(lv(8'hBB, 1'b0, 0, 1'b1));
        lq.push_back(lv(8'hCC, 1'b0, 0, 1'b1));
        lq.push_back(lv(8'hDD, 1'b0, 1, 1'b1));
        lq.push_back(lv(8'h11, 1'b1, 2, 1'b0));
        run_load("pad");
        fq = {};
        fq.push_back(fv(32'h0, 32'hAABB_CCDD));
        fq.push_back(fv(32'h4, 32'h1100_0000));
        run_fetch("pad");

        // ---------------- reset mid-load ----------------
        do_reset();
        send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0);
        send(8'h78, 1'b0); send(8'h9A, 1'b0); send(8'hBC, 1'b0);
        chk("midrst words before", 32'(words_loaded), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst words cleared", 32'(words_loaded), 32'd0);
        chk("midrst ready cleared", 32'(load_ready), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b1);
        chk("midrst words", 32'(words_loaded), 32'd1);
        pc = 32'h0;
        #1;
        chk("midrst instr", instr, 32'h0000_0001);

        // ---------------- gaps between bytes ----------------
        do_reset();
        send(8'h20, 1'b0); idle(3); send(8'h08, 1'b0); idle(3);
        send(8'h00, 1'b0); idle(3); send(8'h05, 1'b0); idle(3);
        send(8'h8C, 1'b0); idle(3); send(8'h09, 1'b0); idle(3);
        send(8'h00, 1'b0); idle(3); send(8'h04, 1'b1);
        chk("gap words", 32'(words_loaded), 32'd2);
        fq = {};
        fq.push_back(fv(32'h0, 32'h2008_0005));
        fq.push_back(fv(32'h4, 32'h8C09_0004));
        fq.push_back(fv(32'h0000_1000, 32'h0));
        run_fetch("gap");

        // ---------------- overflow together with load_last ----------------
        do_reset();
        for (int i = 0; i < 19; i++) send2(8'(i), 1'b0);
        send2(8'hEE, 1'b1);
        chk("ovf+last error", 32'(load_error2), 32'd1);
        chk("ovf+last done", 32'(load_done2), 32'd0);
`else
        // ---------------- checksum match ----------------
        do_reset();
        lq = {};
        lq.push_back(lv(8'h00, 1'b0, 0, 1'b1));
        lq.push_back(lv(8'h00, 1'b0, 0, 1'b1));
        lq.push_back(lv(8'h00, 1'b0, 0, 1'b1));
        lq.push_back(lv(8'h01, 1'b0, 1, 1'b1));
        lq.push_back(lv(8'h00, 1'b0, 1, 1'b1));
        lq.push_back(lv(8'h00, 1'b0, 1, 1'b1));
        lq.push_back(lv(8'h00, 1'b0, 1, 1'b1));
        lq.push_back(lv(8'h02, 1'b0, 2, 1'b1));
        lq.push_back(lv(8'h00, 1'b0, 2, 1'b1));
        lq.push_back(lv(8'h00, 1'b0, 2, 1'b1));
        lq.push_back(lv(8'h00, 1'b0, 2, 1'b1));
        lq.push_back(lv(8'h03, 1'b1, 2, 1'b0));
        run_load("csum ok");
        chk("csum ok done", 32'(load_done), 32'd1);
        fq = {};
        fq.push_back(fv(32'h0, 32'h0000_0001));
        fq.push_back(fv(32'h4, 32'h0000_0002));
        run_fetch("csum ok");

        // ---------------- checksum mismatch ----------------
        do_reset();
        lq[11] = lv(8'h04, 1'b1, 2, 1'b1);
        run_load("csum bad");
        chk("csum bad error", 32'(load_error), 32'd1);
        chk("csum bad instr", instr, 32'h0);

        // ---------------- checksum of empty program ----------------
        do_reset();
        send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b1);
        chk("csum empty done", 32'(load_done), 32'd1);
        chk("csum empty words", 32'(words_loaded), 32'd0);
`endif

        // ---------------- overflow on a 4-word array ----------------
        do_reset();
        for (int i = 0; i < 16; i++) send2(8'(i), 1'b0);
        chk("ovf words at 16", 32'(words_loaded2), 32'd4);
        chk("ovf no error at 16", 32'(load_error2), 32'd0);
        for (int i = 16; i < 19; i++) send2(8'(i), 1'b0);
        chk("ovf no error at 19", 32'(load_error2), 32'd0);
        send2(8'h13, 1'b0);
        chk("ovf error", 32'(load_error2), 32'd1);
        chk("ovf core_reset", 32'(core_reset2), 32'd1);
        chk("ovf words", 32'(words_loaded2), 32'd4);
        chk("ovf ready", 32'(load_ready2), 32'd0);
        chk("ovf instr", instr2, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
